seq_div_16b: RTL
================

# seq_div_16b

Iterative unsigned restoring divider for the systolic array MUL datapath. It is the inverse-direction companion of the carry-lookahead adder/multiplier path and is used for normalisation and averaging of accumulated results. Each cycle it performs one trial subtraction, built as addition of the inverted divisor with carry-in 1, and produces one quotient bit. The result follows WIDTH+1 clock edges after a start is accepted, with a start/busy/done handshake.

## Interface
- WIDTH, 16, operand width in bits; dividend, divisor, quotient and remainder are all WIDTH bits.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; captured when start is accepted.
- divisor  input  WIDTH  unsigned denominator; captured when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when quotient and remainder become valid.
- quotient  output  WIDTH  result; held until the next accepted start completes.
- remainder  output  WIDTH  result; held until the next accepted start completes.
- div_by_zero  output  1  flag for the last completed operation; held with the results.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: iterating, WIDTH iterations.
- No separate DONE state. done is a registered pulse.
- IDLE with start=1 and divisor!=0:
  - Capture dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits).
  - Set count to 0 and enter CALC.
- IDLE with start=1 and divisor==0:
  - Do not enter CALC.
  - Load quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1, done=1.
- Each CALC iteration:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed as T = shifted + ~{0,D} + 1 at WIDTH+1 bits.
  - If T has no borrow (T[WIDTH]==0): R<=T and the quotient bit is 1.
  - Otherwise R<=shifted (restore) and the quotient bit is 0.
  - Q<={Q[WIDTH-2:0], qbit}.
- After iteration WIDTH-1 (count==WIDTH-1):
  - quotient<=next Q, remainder<=next R[WIDTH-1:0], div_by_zero<=0, done<=1.
  - Return to IDLE.
- start in CALC is ignored; inputs are not re-sampled.
- start in the IDLE cycle where done=1 is accepted, so back-to-back operation is legal.
- All arithmetic is unsigned; R never exceeds WIDTH+1 bits.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0, R=0, Q=0, D=0.
- Reset asserted mid-CALC aborts immediately to reset values. No done is produced for the aborted operation.

## Timing
- E0 = the rising edge that samples start=1 in IDLE.
- Normal operation:
  - busy=1 from after E0 through the edge E_WIDTH.
  - Iterations occur at E1..E_WIDTH.
  - At E_WIDTH, busy falls and done rises together. done is high for exactly one cycle.
  - Latency: the result is valid WIDTH+1 edges after the start sample, i.e. 17 cycles for WIDTH=16.
- Divide-by-zero:
  - done=1 and results are valid in the cycle after E0 (latency 1).
  - busy stays 0.
- quotient, remainder and div_by_zero change only at the edge that raises done, and otherwise hold.
- Throughput: one division per WIDTH+1 cycles when start is held high continuously.

## Test plan
- Basic: dividend=1000, divisor=7, start for 1 cycle -> done in the 17th cycle after E0 with quotient=142, remainder=6, div_by_zero=0. busy must be high for exactly 16 cycles.
- Extremes:
  - 0xFFFF/1 -> q=0xFFFF, r=0.
  - 0xFFFF/0xFFFF -> q=1, r=0.
  - 3/10 -> q=0, r=3.
  - 0/5 -> q=0, r=0.
- Divide-by-zero: 5/0 -> done one cycle after E0, q=0xFFFF, r=5, div_by_zero=1, busy never high. A following 9/3 -> q=3, r=0, div_by_zero=0.
- Ignored start: 100/9 started, then start pulsed with 50/2 at E5 -> result q=11, r=1. No second done unless start is reasserted in IDLE.
- Back-to-back: start held high with 1000/7 then 60000/250 -> two done pulses 17 cycles apart: (142,6) then (240,0).
- Reset mid-operation: assert rst at E8 of 1000/7 -> all outputs 0 immediately (asynchronously) and no done. After release, 12345/67 -> q=184, r=17.

Source files
------------

// File: rtl/seq_div_16b.sv
// Iterative unsigned restoring divider: one trial subtraction and one quotient
// bit per cycle, with a start/busy/done handshake and a divide-by-zero shortcut.
module seq_div_16b #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   // The partial remainder always stays below the divisor, so only the trial
   // value needs the extra borrow bit; the stored remainder fits in WIDTH bits.
   always_comb begin
      shifted = {r, q[WIDTH-1]};
      trial   = shifted + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
      qbit    = ~trial[WIDTH];
      r_next  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      q_next  = {q[WIDTH-2:0], qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     q     <= dividend;
                     d     <= divisor;
                     r     <= '0;
                     count <= '0;
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               q     <= q_next;
               r     <= r_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
